fifo_reader: RTL and testbench

Read-side consumer for the team's synchronous FIFO. Issues `rd_en` pulses toward the FIFO, qualifies each returned word with the FIFO's registered `empty` status, and packs `PACK` consecutive words into one wide beat. Beats go downstream over a valid/ready handshake. Sits between a FIFO instance and any wide-bus consumer; the FIFO's read port connects directly to the `fifo_*` ports.

---
 rtl/fifo_reader_if.sv | 27 ++
 rtl/fifo_reader.sv | 122 ++++++++++++
 tb/tb_fifo_reader.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// FIFO read port plus the downstream wide-beat handshake of fifo_reader.
// master = the reader itself, slave = the FIFO/consumer side.
interface fifo_reader_if #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4
);
    localparam int CW = $clog2(PACK + 1);

    logic [WIDTH-1:0]      fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic                  flush;
    logic [WIDTH*PACK-1:0] m_data;
    logic [CW-1:0]         m_cnt;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_data_out, fifo_empty, flush, m_ready,
        output fifo_rd_en, m_data, m_cnt, m_valid
    );

    modport slave (
        output fifo_data_out, fifo_empty, flush, m_ready,
        input  fifo_rd_en, m_data, m_cnt, m_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// Read-side FIFO consumer: issues reads, keeps only words returned with empty=0,
// and packs PACK of them (or fewer on flush) into one valid/ready beat.
module fifo_reader #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4
) (
    input  logic          clk,
    input  logic          rst,
    fifo_reader_if.master bus
);
    localparam int              CW       = $clog2(PACK + 1);
    localparam int              DW       = WIDTH * PACK;
    localparam logic [CW-1:0]   PACK_CNT = CW'(PACK);
    localparam logic [CW:0]     PACK_EXT = (CW + 1)'(PACK);

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_pending;
    logic          r_flush_req, w_flush_req_nxt;
    logic [DW-1:0] r_data, w_data_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_valid, w_valid_nxt;

    logic [CW:0]   w_inflight;
    logic [CW-1:0] w_count_inc;
    logic          w_rd_en;
    logic          w_capture;
    logic          w_handshake;

    // One bit wider than count so count + pending can reach PACK without wrapping.
    assign w_inflight  = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
    assign w_count_inc = r_count + CW'(1);

    assign w_rd_en     = !rst && (r_state == S_FILL) && !bus.fifo_empty
                         && (w_inflight < PACK_EXT) && !r_flush_req;
    assign w_capture   = (r_state == S_FILL) && r_pending && !bus.fifo_empty;
    assign w_handshake = r_valid && bus.m_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path holds a stale value and no latch is inferred.
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_flush_req_nxt = r_flush_req;
        w_data_nxt      = r_data;
        w_cnt_nxt       = r_cnt;
        w_valid_nxt     = r_valid;

        case (r_state)
            S_FILL: begin
                if (bus.flush && ((r_count != '0) || r_pending))
                    w_flush_req_nxt = 1'b1;

                if (w_capture) begin
                    for (int i = 0; i < PACK; i++) begin
                        if (r_count == CW'(i))
                            w_data_nxt[i*WIDTH +: WIDTH] = bus.fifo_data_out;
                    end
                    w_count_nxt = w_count_inc;
                end

                if (w_capture && (w_count_inc == PACK_CNT)) begin
                    w_state_nxt = S_HOLD;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = PACK_CNT;
                end else if (r_flush_req && !r_pending) begin
                    // Outstanding response absorbed: emit what we have, or drop the request.
                    if (r_count != '0) begin
                        w_state_nxt = S_HOLD;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = r_count;
                    end else begin
                        w_flush_req_nxt = 1'b0;
                    end
                end
            end

            S_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt     = S_FILL;
                    w_count_nxt     = '0;
                    w_flush_req_nxt = 1'b0;
                    w_data_nxt      = '0;
                    w_cnt_nxt       = '0;
                    w_valid_nxt     = 1'b0;
                end
            end

            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
        if (rst) begin
            r_state     <= S_FILL;
            r_count     <= '0;
            r_pending   <= 1'b0;
            r_flush_req <= 1'b0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_pending   <= w_rd_en;
            r_flush_req <= w_flush_req_nxt;
            r_data      <= w_data_nxt;
            r_cnt       <= w_cnt_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_data     = r_data;
    assign bus.m_cnt      = r_cnt;
    assign bus.m_valid    = r_valid;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: emulates a FIFO read port with a stale registered empty flag,
// checks a queue-based model every cycle, and pins it with hand-computed scenarios.
module tb_fifo_reader;
    localparam int WIDTH = 8;
    localparam int PACK  = 4;
    localparam int CW    = $clog2(PACK + 1);
    localparam int DW    = WIDTH * PACK;
    localparam int HIST  = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_reader_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();
    fifo_reader #(.WIDTH(WIDTH), .PACK(PACK)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO emulation: words still stored, the word handed back on a failed read, last-cycle read.
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] junk_word = 8'h5A;
    logic             rd_seen   = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_seen) begin
            if (fq.size() > 0) begin
                bus.fifo_data_out = fq.pop_front();
                bus.fifo_empty    = 1'b0;
            end else begin
                bus.fifo_data_out = junk_word;
                bus.fifo_empty    = 1'b1;
            end
        end else begin
            bus.fifo_empty = (fq.size() == 0);
        end
    endtask

    // Per-cycle history of DUT outputs, indexed by cycle number.
    int            cyc = 0;
    logic          hist_rd   [HIST];
    logic          hist_vld  [HIST];
    logic [CW-1:0] hist_cnt  [HIST];
    logic [DW-1:0] hist_data [HIST];

    // Behavioural model: captured words as a queue, one outstanding-request flag.
    logic [WIDTH-1:0] mdl_words[$];
    bit               mdl_out  = 1'b0;
    bit               mdl_freq = 1'b0;
    bit               mdl_hold = 1'b0;
    bit               mdl_live = 1'b0;
    logic [DW-1:0]    mdl_beat = '0;
    int               mdl_beat_cnt = 0;

    function automatic logic [DW-1:0] packed_words();
        logic [DW-1:0] b;
        b = '0;
        foreach (mdl_words[i]) b[i*WIDTH +: WIDTH] = mdl_words[i];
        return b;
    endfunction

    always @(negedge clk) begin
        bit exp_rd;
        bit had_words;
        bit may_close;
        exp_rd = !rst && !mdl_hold && !bus.fifo_empty && !mdl_freq
                 && ((mdl_words.size() + int'(mdl_out)) < PACK);

        if (mdl_live) begin
            check("rd_en", 64'(bus.fifo_rd_en), 64'(exp_rd));
            check("m_valid", 64'(bus.m_valid), 64'(mdl_hold));
            if (mdl_hold) begin
                check("m_cnt", 64'(bus.m_cnt), 64'(mdl_beat_cnt));
                check("m_data", 64'(bus.m_data), 64'(mdl_beat));
            end else begin
                check("m_cnt_idle", 64'(bus.m_cnt), 64'd0);
            end
        end

        if (cyc < HIST) begin
            hist_rd[cyc]   <= bus.fifo_rd_en;
            hist_vld[cyc]  <= bus.m_valid;
            hist_cnt[cyc]  <= bus.m_cnt;
            hist_data[cyc] <= bus.m_data;
        end
        cyc     <= cyc + 1;
        rd_seen <= bus.fifo_rd_en;

        // Advance the model to the state after the coming rising edge.
        if (rst) begin
            mdl_words.delete();
            mdl_out      = 1'b0;
            mdl_freq     = 1'b0;
            mdl_hold     = 1'b0;
            mdl_beat     = '0;
            mdl_beat_cnt = 0;
            mdl_live     = 1'b1;
        end else if (mdl_hold) begin
            if (bus.m_ready) begin
                mdl_hold = 1'b0;
                mdl_freq = 1'b0;
                mdl_words.delete();
            end
            mdl_out = 1'b0;
        end else begin
            had_words = (mdl_words.size() > 0);
            may_close = mdl_freq && !mdl_out;
            if (bus.flush && (had_words || mdl_out)) mdl_freq = 1'b1;
            if (mdl_out && !bus.fifo_empty) mdl_words.push_back(bus.fifo_data_out);
            if (mdl_words.size() == PACK) begin
                mdl_hold     = 1'b1;
                mdl_beat     = packed_words();
                mdl_beat_cnt = PACK;
            end else if (may_close) begin
                if (mdl_words.size() > 0) begin
                    mdl_hold     = 1'b1;
                    mdl_beat     = packed_words();
                    mdl_beat_cnt = mdl_words.size();
                end else begin
                    mdl_freq = 1'b0;
                end
            end
            mdl_out = exp_rd;
        end
    end

    function automatic int count_rd(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i < b; i++) if (i >= 0 && i < HIST && hist_rd[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_vld(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i < b; i++) if (i >= 0 && i < HIST && hist_vld[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_rd(input int a, input int b);
        for (int i = a; i < b; i++) if (i >= 0 && i < HIST && hist_rd[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int first_vld(input int a, input int b);
        for (int i = a; i < b; i++) if (i >= 0 && i < HIST && hist_vld[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic logic [63:0] data_at(input int i);
        if (i < 0 || i >= HIST) return 'x;
        return 64'(hist_data[i]);
    endfunction

    function automatic logic [63:0] cnt_at(input int i);
        if (i < 0 || i >= HIST) return 'x;
        return 64'(hist_cnt[i]);
    endfunction

    function automatic logic [63:0] bit_at(input int i, input bit rd);
        if (i < 0 || i >= HIST) return 'x;
        return rd ? 64'(hist_rd[i]) : 64'(hist_vld[i]);
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        bus.flush = 1'b0;
        bus.m_ready = 1'b0;
        fq.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int s, e, f, h, p, v, stable;
        bus.fifo_data_out = '0;
        bus.fifo_empty    = 1'b1;
        bus.flush         = 1'b0;
        bus.m_ready       = 1'b0;

        // Reset state.
        do_reset();
        tick();
        check("reset_m_valid", 64'(bus.m_valid), 64'd0);
        check("reset_m_cnt", 64'(bus.m_cnt), 64'd0);
        check("reset_m_data", 64'(bus.m_data), 64'd0);
        check("reset_rd_en", 64'(bus.fifo_rd_en), 64'd0);

        // Four words, consumer always ready.
        do_reset();
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        bus.m_ready = 1'b1;
        s = cyc;
        repeat (14) tick();
        e = cyc;
        f = first_rd(s, e);
        v = first_vld(s, e);
        check("t1_rd_total", 64'(count_rd(s, e)), 64'd4);
        check("t1_rd_consecutive", 64'(count_rd(f, f + 4)), 64'd4);
        check("t1_latency", 64'(v - f), 64'(PACK + 1));
        check("t1_valid_cycles", 64'(count_vld(s, e)), 64'd1);
        check("t1_data", data_at(v), 64'h44332211);
        check("t1_cnt", cnt_at(v), 64'd4);

        // Six words, consumer stalled: four reads, beat held, fifth read after handshake.
        do_reset();
        for (int i = 1; i <= 6; i++) fq.push_back(WIDTH'(i));
        bus.m_ready = 1'b0;
        s = cyc;
        repeat (12) tick();
        h = cyc;
        bus.m_ready = 1'b1;
        repeat (4) tick();
        bus.m_ready = 1'b0;
        check("t2_reads_before_hs", 64'(count_rd(s, h + 1)), 64'd4);
        stable = 0;
        for (int i = s + 6; i <= h; i++)
            if (bit_at(i, 1'b0) == 64'd1 && data_at(i) == 64'h04030201 && cnt_at(i) == 64'd4) stable++;
        check("t2_beat_held", 64'(stable), 64'(h - s - 5));
        check("t2_valid_drops", bit_at(h + 1, 1'b0), 64'd0);
        check("t2_no_read_in_hs", bit_at(h, 1'b1), 64'd0);
        check("t2_read_after_hs", bit_at(h + 1, 1'b1), 64'd1);

        // Two words, stale empty leads to a failed third read (returns 0x5A), then flush.
        do_reset();
        junk_word = 8'h5A;
        fq.push_back(8'hA1); fq.push_back(8'hB2);
        bus.m_ready = 1'b1;
        s = cyc;
        repeat (8) tick();
        p = cyc;
        check("t3_reads", 64'(count_rd(s, p)), 64'd3);
        check("t3_no_beat", 64'(count_vld(s, p)), 64'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (5) tick();
        e = cyc;
        v = first_vld(p, e);
        check("t3_flush_latency", 64'(v - p), 64'd2);
        check("t3_data", data_at(v), 64'h0000B2A1);
        check("t3_cnt", cnt_at(v), 64'd2);
        check("t3_no_more_reads", 64'(count_rd(p, e)), 64'd0);

        // Flush while a read is outstanding that fails with nothing captured.
        do_reset();
        bus.m_ready = 1'b1;
        tick();
        s = cyc;
        bus.fifo_empty = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (3) tick();
        fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3); fq.push_back(8'hC4);
        repeat (10) tick();
        e = cyc;
        check("t4_stale_read", bit_at(s, 1'b1), 64'd1);
        check("t4_no_beat", 64'(count_vld(s, s + 6)), 64'd0);
        v = first_vld(s, e);
        check("t4_resume_data", data_at(v), 64'hC4C3C2C1);
        check("t4_resume_cnt", cnt_at(v), 64'd4);

        // Reset in the response cycle: D1 is dropped, only D2 is packed later.
        do_reset();
        fq.push_back(8'hD1); fq.push_back(8'hD2);
        bus.m_ready = 1'b1;
        tick();
        f = cyc;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        e = cyc;
        check("t5_read_before_rst", bit_at(f, 1'b1), 64'd1);
        check("t5_no_read_in_rst", bit_at(f + 1, 1'b1), 64'd0);
        check("t5_data_cleared", data_at(f + 2), 64'd0);
        check("t5_cnt_cleared", cnt_at(f + 2), 64'd0);
        check("t5_no_beat", 64'(count_vld(f, e)), 64'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (4) tick();
        v = first_vld(e, cyc);
        check("t5_flush_data", data_at(v), 64'h000000D2);
        check("t5_flush_cnt", cnt_at(v), 64'd1);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (fq.size() < 64 && $urandom_range(0, 99) < 35) fq.push_back(WIDTH'($urandom));
            bus.m_ready = ($urandom_range(0, 99) < 60);
            bus.flush   = ($urandom_range(0, 99) < 5);
            junk_word   = WIDTH'($urandom);
            rst         = ($urandom_range(0, 999) < 4);
            tick();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
